gray_seq_checker: RTL and testbench
===================================

// Module: gray_seq_checker
// PURPOSE
//  Receive-side partner of the 3-bit Gray-code up-counter. Takes the Gray-coded count stream
//  presented with a valid strobe, decodes it to binary, and checks that successive samples
//  form a legal forward Gray sequence. Tracks wrap-arounds and raises a sticky error on any
//  illegal transition. Sits at the consumer end of the Gray counter link.
// PARAMETERS
//  WIDTH   3  Gray/binary code width in bits (>=2)
//  WRAP_W  4  width of the saturating wrap counter
// PORTS
//  Clk       in   1        clock, all state updates on posedge
//  Reset     in   1        synchronous, active-high; highest priority
//  Resync    in   1        leave ERROR/TRACK, re-acquire reference; clears Err
//  In_valid  in   1        Gray_in carries a sample this cycle
//  Gray_in   in   WIDTH    Gray-coded count sample
//  Bin_out   out  WIDTH    registered binary decode of last accepted sample
//  Out_valid out  1        one-cycle pulse: Bin_out updated this cycle
//  Wrap_cnt  out  WRAP_W   number of legal max->0 wraps, saturating
//  Overflow  out  1        sticky: at least one legal wrap seen
//  Err       out  1        sticky: illegal transition detected
// BEHAVIOUR
//  Interface: Reset is synchronous, active-high; clock is Clk.
//  Reset values: Bin_out=0, Out_valid=0, Wrap_cnt=0, Overflow=0, Err=0, state=IDLE, prev=0.
//  Decode: b[WIDTH-1]=g[WIDTH-1]; b[i]=b[i+1]^g[i] for i<WIDTH-1. Combinational decode of
//   Gray_in, then registered. Latency 1: sample at edge N -> Bin_out/Out_valid at edge N+1.
//  Out_valid = In_valid registered, in every state except when Reset is asserted.
//  Bin_out holds its value while In_valid=0. There is no backpressure.
//  Legality of sample s vs prev (binary, mod 2^WIDTH):
//   s==prev          -> REPEAT, legal, no counter change
//   s==prev+1        -> STEP, legal
//   prev==max, s==0  -> WRAP, legal; Wrap_cnt+=1 (saturate at all-ones), Overflow<=1
//   anything else    -> ILLEGAL. This includes backward steps and multi-bit Gray changes.
//  FSM:
//   IDLE : first valid sample becomes prev, no check, ->TRACK
//   TRACK: each valid sample is checked; legal -> prev<=s, stay;
//          ILLEGAL -> Err<=1 (same edge Out_valid rises), prev<=s, ->ERROR
//   ERROR: samples still decoded and output, prev<=s; no legality check, no wrap counting;
//          Err stays 1
//  Resync=1 (no Reset): state->IDLE, Err<=0; Wrap_cnt/Overflow kept.
//   If In_valid is also 1, the sample is decoded and output and becomes the new prev,
//   and the state goes directly to TRACK (no check).
//  Reset mid-stream: all state returns to reset values; the next sample is handled as in IDLE.
//  Err/Overflow are never cleared except by Reset; Resync also clears Err.
// TESTING
//  1 Reset; Gray 000,001,011,010,110,111,101,100 on consecutive cycles -> Bin_out 0..7,
//    each 1 cycle later, Out_valid high 8 cycles, Err=0, Overflow=0
//  2 Continue with 000 -> Bin_out=0, Wrap_cnt=1, Overflow=1, Err=0; second full lap -> Wrap_cnt=2
//  3 Samples 000 then 011 (2-bit jump) -> Err=1 on the Bin_out=2 cycle; further legal
//    samples keep Err=1 and do not change Wrap_cnt; Resync pulse -> Err=0, next 000,001 legal
//  4 Samples 011 then 001 (backward 2->1, 1-bit Gray change) -> Err=1
//  5 011, idle 3 cycles, 011, 010 -> Out_valid exactly 3 pulses, Bin_out 2,2,3, Err=0
//  6 WRAP_W=2: 5 full laps -> Wrap_cnt saturates at 3; Reset mid-lap -> all outputs 0,
//    next sample (e.g. 110) accepted as reference without Err

Source files
------------

// File: rtl/gray_seq_checker_if.sv
// rtl/gray_seq_checker_if.sv - sample stream and status bundle between the Gray link and its checker.
interface gray_seq_checker_if #(
  parameter int WIDTH  = 3,
  parameter int WRAP_W = 4
);
  logic              Resync;
  logic              In_valid;
  logic [WIDTH-1:0]  Gray_in;
  logic [WIDTH-1:0]  Bin_out;
  logic              Out_valid;
  logic [WRAP_W-1:0] Wrap_cnt;
  logic              Overflow;
  logic              Err;

  modport master (
    output Resync, In_valid, Gray_in,
    input  Bin_out, Out_valid, Wrap_cnt, Overflow, Err
  );

  modport slave (
    input  Resync, In_valid, Gray_in,
    output Bin_out, Out_valid, Wrap_cnt, Overflow, Err
  );
endinterface

// File: rtl/gray_seq_checker.sv
// rtl/gray_seq_checker.sv - decodes a Gray count stream and checks it advances legally.
// Counts legal max->0 wraps (saturating) and flags any illegal transition with a sticky error.
module gray_seq_checker #(
  parameter int WIDTH  = 3,
  parameter int WRAP_W = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  gray_seq_checker_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    ERROR = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0]  MAX_CODE = '1;
  localparam logic [WIDTH-1:0]  ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WRAP_W-1:0] ONE_WRAP = {{(WRAP_W-1){1'b0}}, 1'b1};

  state_t             r_state;
  logic [WIDTH-1:0]   r_prev;
  logic [WIDTH-1:0]   r_bin;
  logic               r_out_valid;
  logic [WRAP_W-1:0]  r_wrap_cnt;
  logic               r_overflow;
  logic               r_err;

  logic [WIDTH-1:0]   w_bin;
  logic [WIDTH-1:0]   w_prev_inc;
  logic               w_repeat;
  logic               w_step;
  logic               w_wrap;

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    w_bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_bin[i] = ^(bus.Gray_in >> i);
    end
  end

  assign w_prev_inc = r_prev + ONE_W;
  assign w_repeat   = (w_bin == r_prev);
  assign w_wrap     = (r_prev == MAX_CODE) && (w_bin == '0);
  assign w_step     = (r_prev != MAX_CODE) && (w_bin == w_prev_inc);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_prev      <= '0;
      r_bin       <= '0;
      r_out_valid <= 1'b0;
      r_wrap_cnt  <= '0;
      r_overflow  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_out_valid <= bus.In_valid;
      if (bus.In_valid) begin
        r_bin <= w_bin;
      end

      if (bus.Resync) begin
        // A sample arriving with Resync is taken as the new reference directly.
        r_err <= 1'b0;
        if (bus.In_valid) begin
          r_prev  <= w_bin;
          r_state <= TRACK;
        end else begin
          r_state <= IDLE;
        end
      end else if (bus.In_valid) begin
        r_prev <= w_bin;
        case (r_state)
          IDLE: begin
            r_state <= TRACK;
          end
          TRACK: begin
            if (w_wrap) begin
              r_overflow <= 1'b1;
              if (r_wrap_cnt != '1) begin
                r_wrap_cnt <= r_wrap_cnt + ONE_WRAP;
              end
            end else if (!(w_repeat || w_step)) begin
              r_err   <= 1'b1;
              r_state <= ERROR;
            end
          end
          ERROR: begin
            r_state <= ERROR;
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.Bin_out   = r_bin;
  assign bus.Out_valid = r_out_valid;
  assign bus.Wrap_cnt  = r_wrap_cnt;
  assign bus.Overflow  = r_overflow;
  assign bus.Err       = r_err;

endmodule

// File: tb/tb_gray_seq_checker.sv
// tb/tb_gray_seq_checker.sv - vector table plus scoreboard for gray_seq_checker.
// A second instance with a 2-bit wrap counter covers saturation and mid-lap reset.
module tb_gray_seq_checker;

  logic Clk;
  logic rst1;
  logic rst2;

  gray_seq_checker_if #(.WIDTH(3), .WRAP_W(4)) b1 ();
  gray_seq_checker_if #(.WIDTH(3), .WRAP_W(2)) b2 ();

  gray_seq_checker #(.WIDTH(3), .WRAP_W(4)) u_dut1 (
    .Clk   (Clk),
    .Reset (rst1),
    .bus   (b1)
  );

  gray_seq_checker #(.WIDTH(3), .WRAP_W(2)) u_dut2 (
    .Clk   (Clk),
    .Reset (rst2),
    .bus   (b2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic       v;
    logic [2:0] g;
    logic       rs;
    logic [2:0] eb;
    logic [3:0] ew;
    logic       eo;
    logic       ee;
  } vec_t;

  vec_t       tv[$];
  logic [2:0] sb_q[$];
  logic [2:0] last_bin;
  int         n_checks;
  int         n_pass;
  int         n_pulses;
  int         n_valid;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic void add(input logic v, input logic [2:0] g, input logic rs,
                              input logic [2:0] eb, input logic [3:0] ew,
                              input logic eo, input logic ee);
    vec_t t;
    t.v = v; t.g = g; t.rs = rs; t.eb = eb; t.ew = ew; t.eo = eo; t.ee = ee;
    tv.push_back(t);
  endfunction

  task automatic apply1(input vec_t t);
    logic [2:0] e;
    b1.Resync   = t.rs;
    b1.In_valid = t.v;
    b1.Gray_in  = t.g;
    if (t.v) begin
      sb_q.push_back(t.eb);
      n_valid++;
    end
    @(posedge Clk);
    #1;
    chk("out_valid", int'(b1.Out_valid), int'(t.v));
    if (b1.Out_valid) begin
      n_pulses++;
      if (sb_q.size() == 0) begin
        chk("scoreboard_empty", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk("bin_out", int'(b1.Bin_out), int'(e));
        last_bin = e;
      end
    end else begin
      chk("bin_hold", int'(b1.Bin_out), int'(last_bin));
    end
    chk("err", int'(b1.Err), int'(t.ee));
    chk("wrap_cnt", int'(b1.Wrap_cnt), int'(t.ew));
    chk("overflow", int'(b1.Overflow), int'(t.eo));
  endtask

  task automatic drive2(input logic v, input logic [2:0] g);
    b2.Resync   = 1'b0;
    b2.In_valid = v;
    b2.Gray_in  = g;
    @(posedge Clk);
    #1;
  endtask

  logic [2:0] lap_g [8];
  logic [2:0] lap_b [8];
  int         exp_wraps;

  initial begin
    n_checks = 0; n_pass = 0; n_pulses = 0; n_valid = 0;
    last_bin = 3'd0;
    lap_g = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
    lap_b = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};

    // Lap 1, then wrap and lap 2
    for (int i = 0; i < 8; i++) add(1, lap_g[i], 0, lap_b[i], 4'd0, 0, 0);
    add(1, 3'b000, 0, 3'd0, 4'd1, 1, 0);
    for (int i = 1; i < 8; i++) add(1, lap_g[i], 0, lap_b[i], 4'd1, 1, 0);
    add(1, 3'b000, 0, 3'd0, 4'd2, 1, 0);
    // Repeat 0, jump to 2: error; ERROR state ignores wraps
    add(1, 3'b000, 0, 3'd0, 4'd2, 1, 0);
    add(1, 3'b011, 0, 3'd2, 4'd2, 1, 1);
    for (int i = 3; i < 8; i++) add(1, lap_g[i], 0, lap_b[i], 4'd2, 1, 1);
    add(1, 3'b000, 0, 3'd0, 4'd2, 1, 1);
    add(0, 3'b000, 1, 3'd0, 4'd2, 1, 0);
    add(1, 3'b000, 0, 3'd0, 4'd2, 1, 0);
    add(1, 3'b001, 0, 3'd1, 4'd2, 1, 0);
    // Backward 2->1
    add(1, 3'b011, 0, 3'd2, 4'd2, 1, 0);
    add(1, 3'b001, 0, 3'd1, 4'd2, 1, 1);
    // Resync with a sample: new reference, straight to TRACK
    add(1, 3'b000, 1, 3'd0, 4'd2, 1, 0);
    add(1, 3'b001, 0, 3'd1, 4'd2, 1, 0);
    add(1, 3'b011, 1, 3'd2, 4'd2, 1, 0);
    // Gaps: 011, idle x3, 011, 010
    add(0, 3'b000, 0, 3'd0, 4'd2, 1, 0);
    add(0, 3'b000, 0, 3'd0, 4'd2, 1, 0);
    add(0, 3'b000, 0, 3'd0, 4'd2, 1, 0);
    add(1, 3'b011, 0, 3'd2, 4'd2, 1, 0);
    add(1, 3'b010, 0, 3'd3, 4'd2, 1, 0);

    b1.Resync = 0; b1.In_valid = 0; b1.Gray_in = '0;
    b2.Resync = 0; b2.In_valid = 0; b2.Gray_in = '0;
    rst1 = 1'b1; rst2 = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_bin", int'(b1.Bin_out), 0);
    chk("rst_out_valid", int'(b1.Out_valid), 0);
    chk("rst_wrap", int'(b1.Wrap_cnt), 0);
    chk("rst_overflow", int'(b1.Overflow), 0);
    chk("rst_err", int'(b1.Err), 0);
    rst1 = 1'b0; rst2 = 1'b0;

    foreach (tv[i]) apply1(tv[i]);
    b1.In_valid = 1'b0; b1.Resync = 1'b0;
    chk("pulse_total", n_pulses, n_valid);
    chk("scoreboard_drained", sb_q.size(), 0);

    // Saturating 2-bit wrap counter over 5 laps
    exp_wraps = 0;
    drive2(1, lap_g[0]);
    for (int lap = 0; lap < 5; lap++) begin
      for (int i = 1; i < 8; i++) drive2(1, lap_g[i]);
      drive2(1, lap_g[0]);
      exp_wraps = (exp_wraps < 3) ? exp_wraps + 1 : 3;
      chk("sat_wrap", int'(b2.Wrap_cnt), exp_wraps);
      chk("sat_overflow", int'(b2.Overflow), 1);
      chk("sat_err", int'(b2.Err), 0);
    end
    drive2(1, lap_g[1]);
    drive2(1, lap_g[2]);
    chk("midlap_bin", int'(b2.Bin_out), 2);
    rst2 = 1'b1;
    drive2(1, lap_g[3]);
    rst2 = 1'b0;
    chk("mid_rst_bin", int'(b2.Bin_out), 0);
    chk("mid_rst_out_valid", int'(b2.Out_valid), 0);
    chk("mid_rst_wrap", int'(b2.Wrap_cnt), 0);
    chk("mid_rst_overflow", int'(b2.Overflow), 0);
    chk("mid_rst_err", int'(b2.Err), 0);
    drive2(1, 3'b110);
    chk("ref_bin", int'(b2.Bin_out), 4);
    chk("ref_out_valid", int'(b2.Out_valid), 1);
    chk("ref_err", int'(b2.Err), 0);
    drive2(1, 3'b111);
    chk("ref_next_bin", int'(b2.Bin_out), 5);
    chk("ref_next_err", int'(b2.Err), 0);
    drive2(0, 3'b000);
    chk("idle_out_valid", int'(b2.Out_valid), 0);
    chk("idle_bin_hold", int'(b2.Bin_out), 5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
